// File: rtl/aes_pkg.sv
// Shared AES-128 definitions used by the key-schedule slice.
// Contents: round/word counts, word/block/index types, rcon constants,
// key-expansion FSM state encoding and the GF(2^8) xtime helper.
package aes_pkg;

    localparam int unsigned NR      = 10;
    localparam int unsigned NK      = 4;
    localparam int unsigned NRK     = NR + 1;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned BLOCK_W = NK * WORD_W;
    localparam int unsigned IDX_W   = 4;

    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RCON_POLY = 8'h1b;

    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [BLOCK_W-1:0] block_t;
    typedef logic [IDX_W-1:0]   idx_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// Handshake bundle between the key-schedule engine and its consumer.
//   start/key_in     : expansion request and cipher key
//   busy/done        : engine status, done is a one-cycle completion pulse
//   rk_valid/rk_ready: round-key stream handshake carrying rk_out/rk_idx
//   rk_rd_idx/rk_rd_data: random-access read of stored round keys, present
//                     only when AES_KEY_EXPAND_STORE_EN is defined
// master = consumer side, slave = engine side.
interface aes_key_expand_if;
    import aes_pkg::*;

    logic   start;
    block_t key_in;
    logic   busy;
    logic   rk_valid;
    logic   rk_ready;
    block_t rk_out;
    idx_t   rk_idx;
    logic   done;
`ifdef AES_KEY_EXPAND_STORE_EN
    idx_t   rk_rd_idx;
    block_t rk_rd_data;

    modport master (
        output start, key_in, rk_ready, rk_rd_idx,
        input  busy, rk_valid, rk_out, rk_idx, done, rk_rd_data
    );
    modport slave (
        input  start, key_in, rk_ready, rk_rd_idx,
        output busy, rk_valid, rk_out, rk_idx, done, rk_rd_data
    );
`else
    modport master (
        output start, key_in, rk_ready,
        input  busy, rk_valid, rk_out, rk_idx, done
    );
    modport slave (
        input  start, key_in, rk_ready,
        output busy, rk_valid, rk_out, rk_idx, done
    );
`endif
endinterface

// File: rtl/aes_sbox.sv
// AES forward byte S-box: multiplicative inverse in GF(2^8) followed by
// the affine transform. Purely combinational.
//   a : input byte
//   s : substituted byte
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] s
);

    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // Inverse as x^254 via an addition chain; 0 maps to 0 naturally.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        return gf_mul(gf_mul(x240, x12), x2);
    endfunction

    logic [7:0] inv_c;

    always_comb begin
        inv_c = gf_inv(a);
        s     = inv_c
              ^ {inv_c[6:0], inv_c[7]}
              ^ {inv_c[5:0], inv_c[7:6]}
              ^ {inv_c[4:0], inv_c[7:5]}
              ^ {inv_c[3:0], inv_c[7:4]}
              ^ 8'h63;
    end

endmodule

// File: rtl/aes_sub_word.sv
// 32-bit SubWord: each byte of the word through its own byte S-box.
//   w : input word
//   s : substituted word
module aes_sub_word
    import aes_pkg::*;
(
    input  word_t w,
    output word_t s
);

    for (genvar g = 0; g < 4; g++) begin : g_byte
        aes_sbox u_sbox (
            .a (w[8*g +: 8]),
            .s (s[8*g +: 8])
        );
    end

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule. Emits round keys 0..10 one per accepted
// rk_valid/rk_ready handshake; each next key is computed combinationally
// from the registered current key.
//   clk, rst : clock, synchronous active-high reset
//   bus      : aes_key_expand_if.slave (start/key_in request, busy/done
//              status, rk_valid/rk_ready/rk_out/rk_idx stream)
// Optional macro AES_KEY_EXPAND_STORE_EN adds an 11-entry round-key store
// readable through rk_rd_idx/rk_rd_data with one cycle of latency.
module aes_key_expand
    import aes_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    aes_key_expand_if.slave   bus
);

    localparam idx_t IDX_LAST = idx_t'(NR);

    state_e     state_q, state_d;
    block_t     rk_out_q, rk_out_d;
    idx_t       rk_idx_q, rk_idx_d;
    logic [7:0] rcon_q, rcon_d;
    logic       rk_valid_q, rk_valid_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic       hs_c;
    word_t      w0_c, w1_c, w2_c, w3_c;
    word_t      rot_c, sub_c, t_c;
    word_t      n0_c, n1_c, n2_c, n3_c;
    block_t     next_key_c;

    assign hs_c = rk_valid_q & bus.rk_ready;

    // Next round key from the current one.
    assign {w0_c, w1_c, w2_c, w3_c} = rk_out_q;
    assign rot_c = {w3_c[23:0], w3_c[31:24]};

    aes_sub_word u_sub_word (
        .w (rot_c),
        .s (sub_c)
    );

    assign t_c        = sub_c ^ {rcon_q, 24'h000000};
    assign n0_c       = w0_c ^ t_c;
    assign n1_c       = w1_c ^ n0_c;
    assign n2_c       = w2_c ^ n1_c;
    assign n3_c       = w3_c ^ n2_c;
    assign next_key_c = {n0_c, n1_c, n2_c, n3_c};

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rk_out_q   <= '0;
            rk_idx_q   <= '0;
            rcon_q     <= RCON_INIT;
            rk_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rk_out_q   <= rk_out_d;
            rk_idx_q   <= rk_idx_d;
            rcon_q     <= rcon_d;
            rk_valid_q <= rk_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (hs_c && (rk_idx_q == IDX_LAST)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs; without a handshake all hold.
    always_comb begin
        rk_out_d   = rk_out_q;
        rk_idx_d   = rk_idx_q;
        rcon_d     = rcon_q;
        rk_valid_d = rk_valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    rk_out_d   = bus.key_in;
                    rk_idx_d   = '0;
                    rcon_d     = RCON_INIT;
                    rk_valid_d = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            RUN: begin
                if (hs_c) begin
                    if (rk_idx_q == IDX_LAST) begin
                        rk_valid_d = 1'b0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                    end else begin
                        rk_out_d = next_key_c;
                        rk_idx_d = rk_idx_q + idx_t'(1);
                        rcon_d   = xtime(rcon_q);
                    end
                end
            end
            default: ;
        endcase
    end

    assign bus.busy     = busy_q;
    assign bus.rk_valid = rk_valid_q;
    assign bus.rk_out   = rk_out_q;
    assign bus.rk_idx   = rk_idx_q;
    assign bus.done     = done_q;

`ifdef AES_KEY_EXPAND_STORE_EN
    block_t rk_mem [NRK];
    block_t rk_rd_data_q;

    // Round-key store, written as each key is handed over; registered read.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NRK; i++) rk_mem[i] <= '0;
            rk_rd_data_q <= '0;
        end else begin
            if (hs_c) rk_mem[rk_idx_q] <= rk_out_q;
            rk_rd_data_q <= (bus.rk_rd_idx <= IDX_LAST) ? rk_mem[bus.rk_rd_idx] : '0;
        end
    end

    assign bus.rk_rd_data = rk_rd_data_q;
`endif

endmodule
